// File: rtl/vt512_result_reader_pkg.sv
// Shared addresses, STATUS layout and result-entry type for the VT512 result reader.
package vt512_pkg;

    localparam logic [31:0] VT512_ADDR_RESULT = 32'h414E_5200;
    localparam logic [31:0] VT512_ADDR_STATUS = 32'h414E_5300;

    localparam int ST_EMPTY     = 0;
    localparam int ST_UNDERFLOW = 1;
    localparam int ST_LAST_SEEN = 2;
    localparam int ST_FULL      = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_LASTS_LSB = 16;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } result_t;

    function automatic logic [31:0] status_word(input logic empty, input logic underflow,
                                                input logic last_seen, input logic full,
                                                input logic [7:0] count, input logic [7:0] lasts);
        logic [31:0] w;
        w = '0;
        w[ST_EMPTY]                   = empty;
        w[ST_UNDERFLOW]               = underflow;
        w[ST_LAST_SEEN]               = last_seen;
        w[ST_FULL]                    = full;
        w[ST_COUNT_LSB +: 8]          = count;
        w[ST_LASTS_LSB +: 8]          = lasts;
        return w;
    endfunction

endpackage

// File: rtl/vt512_result_reader_if.sv
// Wishbone slave bus plus the core-side result stream and interrupt line.
interface vt512_result_reader_if #(parameter int DATA_WIDTH = 32);

    logic                  wbs_stb_i;
    logic                  wbs_cyc_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic                  res_valid_i;
    logic [DATA_WIDTH-1:0] res_data_i;
    logic                  res_last_i;
    logic                  res_ready_o;
    logic                  irq_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output res_valid_i, res_data_i, res_last_i,
        input  wbs_ack_o, wbs_dat_o, res_ready_o, irq_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  res_valid_i, res_data_i, res_last_i,
        output wbs_ack_o, wbs_dat_o, res_ready_o, irq_o
    );

endinterface

// File: rtl/vt512_result_reader_fifo.sv
// Synchronous FIFO with flush; head is the oldest entry, count_next is exposed for lookahead logic.
module vt512_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic [AW:0]      count_next,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // flush overrides any push/pop landing on the same edge
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vt512_result_reader.sv
// Wishbone read-side responder: queues core result words and serves RESULT/STATUS to the host.
module vt512_result_reader
    import vt512_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_AW       = 4,
    parameter int IRQ_THRESHOLD = 8
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    vt512_result_reader_if.slave  bus
);

    result_t            head;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_next;
    logic               full;
    logic               empty;
    logic [FIFO_AW:0]   lasts;
    logic [FIFO_AW:0]   lasts_next;
    logic               underflow, underflow_next;
    logic               last_seen, last_seen_next;
    logic               req, rd_result, rd_status, wr_status;
    logic               push, pop, flush;
    logic [31:0]        rdata;
    logic               unused_bits;

    assign unused_bits = ^{bus.wbs_sel_i[3:1], bus.wbs_dat_i[31:4], bus.wbs_dat_i[0]};

    assign req       = bus.wbs_cyc_i && bus.wbs_stb_i && !bus.wbs_ack_o;
    assign rd_result = req && !bus.wbs_we_i && (bus.wbs_adr_i == VT512_ADDR_RESULT);
    assign rd_status = req && !bus.wbs_we_i && (bus.wbs_adr_i == VT512_ADDR_STATUS);
    assign wr_status = req &&  bus.wbs_we_i && (bus.wbs_adr_i == VT512_ADDR_STATUS)
                           && bus.wbs_sel_i[0];

    // ready is held low during reset so the core never pushes into a state being cleared
    assign bus.res_ready_o = wb_rst_i && !full;
    assign push  = bus.res_valid_i && bus.res_ready_o;
    assign pop   = rd_result && !empty;
    assign flush = wr_status && bus.wbs_dat_i[3];

    vt512_sync_fifo #(
        .WIDTH ($bits(result_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_i),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .wdata      ({bus.res_last_i, bus.res_data_i}),
        .head       (head),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        lasts_next = lasts;
        if (flush)
            lasts_next = '0;
        else if ((push && bus.res_last_i) && !(pop && head.last))
            lasts_next = lasts + 1'b1;
        else if (!(push && bus.res_last_i) && (pop && head.last))
            lasts_next = lasts - 1'b1;
    end

    // a clear in the same request always beats a set
    always_comb begin
        underflow_next = underflow;
        last_seen_next = last_seen;
        if (rd_result && empty)   underflow_next = 1'b1;
        if (pop && head.last)     last_seen_next = 1'b1;
        if (wr_status && bus.wbs_dat_i[1]) underflow_next = 1'b0;
        if (wr_status && bus.wbs_dat_i[2]) last_seen_next = 1'b0;
    end

    always_comb begin
        rdata = '0;
        if (rd_result && !empty)
            rdata = head.data;
        else if (rd_status)
            rdata = status_word(empty, underflow, last_seen, full, 8'(count), 8'(lasts));
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            bus.wbs_ack_o <= 1'b0;
            bus.wbs_dat_o <= '0;
            bus.irq_o     <= 1'b0;
            lasts         <= '0;
            underflow     <= 1'b0;
            last_seen     <= 1'b0;
        end else begin
            bus.wbs_ack_o <= req;
            bus.wbs_dat_o <= rdata;
            bus.irq_o     <= ($unsigned(32'(count_next)) >= $unsigned(IRQ_THRESHOLD))
                             || (lasts_next != '0);
            lasts         <= lasts_next;
            underflow     <= underflow_next;
            last_seen     <= last_seen_next;
        end
    end

endmodule

// File: tb/tb_vt512_result_reader.sv
// Randomized + directed bench for vt512_result_reader against a queue-based reference model.
module tb_vt512_result_reader;
    import vt512_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    vt512_result_reader_if #(.DATA_WIDTH(32)) bus ();

    vt512_result_reader #(
        .DATA_WIDTH    (32),
        .FIFO_DEPTH    (16),
        .FIFO_AW       (4),
        .IRQ_THRESHOLD (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [32:0] q[$];
    logic        m_ack, m_irq, m_uf, m_ls;
    logic [31:0] m_dat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lasts_in_q();
        int n = 0;
        foreach (q[i]) if (q[i][32]) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_status();
        return status_word(q.size() == 0, m_uf, m_ls, q.size() == 16,
                           8'(q.size()), 8'(lasts_in_q()));
    endfunction

    // one clock: predict from current inputs, clock, compare registered outputs
    task automatic step();
        logic        req;
        logic        do_push;
        logic [32:0] e;
        logic [31:0] rd;
        #1;
        chk("res_ready", {31'b0, bus.res_ready_o}, {31'b0, rst_n && (q.size() < 16)});
        if (!rst_n) begin
            q.delete();
            m_ack = 1'b0; m_dat = '0; m_irq = 1'b0; m_uf = 1'b0; m_ls = 1'b0;
        end else begin
            req     = bus.wbs_cyc_i && bus.wbs_stb_i && !m_ack;
            do_push = bus.res_valid_i && (q.size() < 16);
            rd      = '0;
            if (req && !bus.wbs_we_i && bus.wbs_adr_i == VT512_ADDR_STATUS)
                rd = m_status();
            if (req && !bus.wbs_we_i && bus.wbs_adr_i == VT512_ADDR_RESULT) begin
                if (q.size() > 0) begin
                    e  = q.pop_front();
                    rd = e[31:0];
                    if (e[32]) m_ls = 1'b1;
                end else begin
                    m_uf = 1'b1;
                end
            end
            if (do_push) q.push_back({bus.res_last_i, bus.res_data_i});
            if (req && bus.wbs_we_i && bus.wbs_adr_i == VT512_ADDR_STATUS && bus.wbs_sel_i[0]) begin
                if (bus.wbs_dat_i[1]) m_uf = 1'b0;
                if (bus.wbs_dat_i[2]) m_ls = 1'b0;
                if (bus.wbs_dat_i[3]) q.delete();
            end
            m_ack = req;
            m_dat = rd;
            m_irq = (q.size() >= 8) || (lasts_in_q() != 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("ack", {31'b0, bus.wbs_ack_o}, {31'b0, m_ack});
        chk("dat_o", bus.wbs_dat_o, m_dat);
        chk("irq", {31'b0, bus.irq_o}, {31'b0, m_irq});
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] d);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = a;
        step();
        d = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        step();
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] v);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = a; bus.wbs_dat_i = v; bus.wbs_sel_i = 4'hF;
        step();
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        step();
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        bus.res_valid_i = 1'b1; bus.res_data_i = d; bus.res_last_i = last;
        step();
        bus.res_valid_i = 1'b0; bus.res_last_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        n_cmp = 0; n_bad = 0;
        m_ack = 0; m_dat = 0; m_irq = 0; m_uf = 0; m_ls = 0;
        rst_n = 1'b0;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.res_valid_i = 0; bus.res_data_i = 0; bus.res_last_i = 0;

        // reset
        repeat (3) step();
        chk("rst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        chk("rst_irq", {31'b0, bus.irq_o}, 32'd0);
        chk("rst_ready", {31'b0, bus.res_ready_o}, 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", {31'b0, bus.res_ready_o}, 32'd1);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("status_after_rst", d, 32'h0000_0001);

        // three words, last on the third
        push_word(32'hA0, 1'b0);
        push_word(32'hA1, 1'b0);
        push_word(32'hA2, 1'b1);
        chk("irq_after_push", {31'b0, bus.irq_o}, 32'd1);
        wb_rd(VT512_ADDR_RESULT, d); chk("pop_a0", d, 32'hA0);
        wb_rd(VT512_ADDR_RESULT, d); chk("pop_a1", d, 32'hA1);
        wb_rd(VT512_ADDR_RESULT, d); chk("pop_a2", d, 32'hA2);
        chk("irq_drained", {31'b0, bus.irq_o}, 32'd0);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("last_seen", {31'b0, d[2]}, 32'd1);
        wb_wr(VT512_ADDR_STATUS, 32'h4);

        // fill to full, then one extra word that must be refused
        bus.res_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.res_data_i = 32'h100 + i;
            step();
        end
        bus.res_data_i = 32'hDEAD;
        #1 chk("full_ready", {31'b0, bus.res_ready_o}, 32'd0);
        step();
        bus.res_valid_i = 1'b0;
        chk("full_irq", {31'b0, bus.irq_o}, 32'd1);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("full_bit", {31'b0, d[3]}, 32'd1);
        chk("full_count", {24'b0, d[15:8]}, 32'd16);
        wb_rd(VT512_ADDR_RESULT, d);
        chk("full_pop", d, 32'h100);
        #1 chk("ready_after_pop", {31'b0, bus.res_ready_o}, 32'd1);
        wb_wr(VT512_ADDR_STATUS, 32'h8);

        // underflow
        wb_rd(VT512_ADDR_RESULT, d);
        chk("empty_read", d, 32'd0);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("underflow_set", {31'b0, d[1]}, 32'd1);
        wb_wr(VT512_ADDR_STATUS, 32'h2);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("underflow_clr", {31'b0, d[1]}, 32'd0);

        // push and pop on the same edge with count=1
        push_word(32'hB0, 1'b0);
        bus.res_valid_i = 1'b1; bus.res_data_i = 32'hB1;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = VT512_ADDR_RESULT;
        step();
        chk("simul_old_head", bus.wbs_dat_o, 32'hB0);
        bus.res_valid_i = 1'b0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        step();
        wb_rd(VT512_ADDR_STATUS, d);
        chk("simul_count", {24'b0, d[15:8]}, 32'd1);
        wb_rd(VT512_ADDR_RESULT, d);
        chk("simul_next", d, 32'hB1);

        // flush racing a push
        for (int i = 0; i < 10; i++) push_word(32'hC0 + i, 1'b0);
        bus.res_valid_i = 1'b1; bus.res_data_i = 32'hCC;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 1; bus.wbs_sel_i = 4'h1;
        bus.wbs_adr_i = VT512_ADDR_STATUS; bus.wbs_dat_i = 32'h8;
        step();
        bus.res_valid_i = 1'b0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
        step();
        chk("flush_irq", {31'b0, bus.irq_o}, 32'd0);
        wb_rd(VT512_ADDR_STATUS, d);
        chk("flush_status", d, 32'h0000_0001);
        wb_rd(32'h414E_0004, d);
        chk("unknown_addr", d, 32'd0);
        wb_wr(32'h414E_0004, 32'hFFFF_FFFF);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.res_valid_i = ($urandom % 2) == 0;
            bus.res_data_i  = $urandom;
            bus.res_last_i  = ($urandom % 8) == 0;
            bus.wbs_cyc_i   = ($urandom % 3) == 0;
            bus.wbs_stb_i   = bus.wbs_cyc_i;
            bus.wbs_we_i    = ($urandom % 4) == 0;
            bus.wbs_sel_i   = 4'($urandom);
            case ($urandom % 5)
                0, 1:    bus.wbs_adr_i = VT512_ADDR_RESULT;
                2, 3:    bus.wbs_adr_i = VT512_ADDR_STATUS;
                default: bus.wbs_adr_i = $urandom;
            endcase
            bus.wbs_dat_i = $urandom & 32'hFFFF_FFF7;
            if (($urandom % 12) == 0) bus.wbs_dat_i[3] = 1'b1;
            step();
        end

        // reset in the middle of a read
        bus.res_valid_i = 1'b1; bus.res_data_i = 32'h55;
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = VT512_ADDR_RESULT;
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_ack", {31'b0, bus.wbs_ack_o}, 32'd0);
        chk("midrst_dat", bus.wbs_dat_o, 32'd0);
        bus.res_valid_i = 1'b0; bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        step();
        rst_n = 1'b1;
        wb_rd(VT512_ADDR_STATUS, d);
        chk("midrst_status", d, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
